fpga1_flit_mailbox: RTL and testbench
=====================================

// Module: fpga1_flit_mailbox
// PURPOSE
//  Avalon-MM slave mailbox between the NIOS data bus and the flit get/put ports of the FPGA1 top.
//  - TX FIFO buffers NIOS writes and drains them into putFlit.
//  - RX FIFO prefetches getFlit and serves NIOS reads.
//  - Provides status, sticky error bits and a maskable, registered interrupt.
// PARAMETERS
//  DEPTH  8  entries per FIFO (power of 2, 2..128)
//  AW     3  log2(DEPTH); counts are AW+1 bits
// PORTS
//  CLK             in   1   sole clock
//  RST_N           in   1   async active-low reset
//  address         in   3   Avalon word address
//  read            in   1   Avalon read strobe (0 wait, 0 latency)
//  readdata        out  32  Avalon read data, combinational from address
//  write           in   1   Avalon write strobe
//  writedata       in   32  Avalon write data
//  irq             out  1   registered interrupt
//  putFlit_put     out  32  TX FIFO head
//  EN_putFlit_put  out  1   transfer strobe = tx_cnt!=0 & RDY_putFlit_put
//  RDY_putFlit_put in   1   downstream can accept
//  getFlit_get     in   32  flit from downstream
//  EN_getFlit_get  out  1   take strobe = rx_cnt!=DEPTH & RDY_getFlit_get
//  RDY_getFlit_get in   1   downstream has a flit
// BEHAVIOUR
//  Clock/reset: one clock CLK; RST_N is asynchronous, active-low.
//  Reset: FIFOs empty, pointers/counts 0, sticky bits 0, IRQ_EN 0, irq 0; EN_* therefore 0.
//  Register map (readdata is 0 for unmapped addresses):
//   0 STATUS  R  [0] rx_cnt!=0, [1] tx_cnt!=DEPTH, [2] tx_drop, [3] rx_underflow,
//                [15:8] rx_cnt, [23:16] tx_cnt (zero-extended), others 0
//             W  write-1-to-clear bits [2] and [3]
//   1 TX_DATA W  push writedata; if TX full -> data dropped, tx_drop<=1
//   2 RX_DATA R  readdata = RX head, pop same cycle; if empty -> readdata 0, no pop, rx_underflow<=1
//   3 IRQ_EN  RW [0] rx-nonempty enable, [1] tx-empty enable
//  Register side effects apply only while address is in range and read/write is asserted.
//  Drain/fill: one flit per cycle max in each direction, independent of bus traffic.
//   TX FIFO: simultaneous push+drain legal at any count, including full; count unchanged.
//   RX FIFO: simultaneous fill+pop legal; fill uses rx_cnt before the pop (no same-cycle full bypass).
//  Latency: write to TX_DATA -> EN_putFlit_put asserted next cycle (if RDY).
//   getFlit capture -> STATUS[0]=1 next cycle.
//  irq <= (IRQ_EN[0] & rx_cnt_next!=0) | (IRQ_EN[1] & tx_cnt_next==0); asserts 1 cycle after cause.
//  Pointers wrap modulo DEPTH; counts never exceed DEPTH or go below 0.
//  Sticky-set and W1C in the same cycle: set wins.
//  Async reset mid-transfer discards all FIFO contents; no partial flit is emitted.
// CONFIGURATION
//  FLIT_MAILBOX_STATS_EN defined: 32-bit wrapping counters.
//   addr 4 R = flits sent (EN_putFlit_put count); addr 5 R = flits received (EN_getFlit_get count).
//   Write any value to addr 4 clears both counters; reset value 0.
//  Undefined: addr 4/5 read 0, writes ignored, no counter flops.
// TESTING
//  1. Reset, read addr0 -> 0x0000_0002; irq=0, EN_putFlit_put=0, EN_getFlit_get=0.
//  2. RDY_put=1; write 0xDEADBEEF to addr1 -> next cycle putFlit_put=0xDEADBEEF, EN_put=1 for exactly 1 cycle.
//  3. RDY_put=0; write 9 flits (DEPTH 8) -> STATUS tx_cnt=8, [1]=0, [2]=1.
//     Raise RDY_put -> 8 flits in order; W1C bit2 -> bit2 reads 0.
//  4. Present 0x11,0x22 on getFlit with RDY_get=1; IRQ_EN=1 -> irq=1.
//     Reads of addr2 return 0x11, 0x22; irq drops 1 cycle after last pop.
//  5. Read addr2 while empty -> 0, STATUS[3]=1.
//     Same-cycle push+drain at TX count 8 -> count stays 8, no drop.
//  6. With FLIT_MAILBOX_STATS_EN: send 3, receive 2 -> addr4=3, addr5=2; write addr4 -> both 0.

Source files
------------

// File: rtl/fpga1_flit_mailbox_if.sv
// Signal bundle for fpga1_flit_mailbox: Avalon-MM slave bus, interrupt and the putFlit/getFlit handshakes.
// The slave modport is the mailbox's view; master is the view of whatever drives it.
interface fpga1_flit_mailbox_if;
    logic [2:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;
    logic        irq;
    logic [31:0] putFlit_put;
    logic        EN_putFlit_put;
    logic        RDY_putFlit_put;
    logic [31:0] getFlit_get;
    logic        EN_getFlit_get;
    logic        RDY_getFlit_get;

    modport slave (
        input  address, read, write, writedata,
        input  RDY_putFlit_put, getFlit_get, RDY_getFlit_get,
        output readdata, irq, putFlit_put, EN_putFlit_put, EN_getFlit_get
    );

    modport master (
        output address, read, write, writedata,
        output RDY_putFlit_put, getFlit_get, RDY_getFlit_get,
        input  readdata, irq, putFlit_put, EN_putFlit_put, EN_getFlit_get
    );
endinterface

// File: rtl/fpga1_flit_mailbox.sv
// Avalon-MM mailbox between the NIOS data bus and the FPGA1 putFlit/getFlit ports (TX/RX FIFOs, status, irq).
// Define FLIT_MAILBOX_STATS_EN to build the sent/received flit counters at addresses 4 and 5.
module fpga1_flit_mailbox #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RST_N,
    fpga1_flit_mailbox_if.slave bus
);

    typedef enum logic [2:0] {
        REG_STATUS  = 3'd0,
        REG_TX_DATA = 3'd1,
        REG_RX_DATA = 3'd2,
        REG_IRQ_EN  = 3'd3,
        REG_SENT    = 3'd4,
        REG_RECV    = 3'd5
    } reg_addr_e;

    typedef logic [AW:0]   cnt_t;
    typedef logic [AW-1:0] ptr_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam ptr_t PTR_ONE  = ptr_t'(1);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic wr_status;
    logic wr_tx;
    logic wr_irq_en;
    logic rd_rx;

    assign wr_status = bus.write && (bus.address == REG_STATUS);
    assign wr_tx     = bus.write && (bus.address == REG_TX_DATA);
    assign wr_irq_en = bus.write && (bus.address == REG_IRQ_EN);
    assign rd_rx     = bus.read  && (bus.address == REG_RX_DATA);

    // ------------------------------------------------------------------
    // TX FIFO: NIOS writes in, putFlit out
    // ------------------------------------------------------------------
    logic [31:0] tx_mem [DEPTH];
    ptr_t        tx_wr_ptr;
    ptr_t        tx_rd_ptr;
    cnt_t        tx_cnt;
    cnt_t        tx_cnt_next;
    logic        tx_empty;
    logic        tx_full;
    logic        tx_drain;
    logic        tx_push;
    logic        tx_drop_set;

    assign tx_empty    = (tx_cnt == '0);
    assign tx_full     = (tx_cnt == CNT_FULL);
    assign tx_drain    = !tx_empty && bus.RDY_putFlit_put;
    // A full FIFO still accepts a write in a cycle where it drains: the freed slot is the one written.
    assign tx_push     = wr_tx && (!tx_full || tx_drain);
    assign tx_drop_set = wr_tx && !tx_push;

    always_comb begin
        // NOTE: every always_comb output gets its default first, so no path leaves it unassigned and no latch is inferred.
        tx_cnt_next = tx_cnt;
        if (tx_push && !tx_drain) begin
            tx_cnt_next = tx_cnt + CNT_ONE;
        end else if (tx_drain && !tx_push) begin
            tx_cnt_next = tx_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (tx_push)  tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            if (tx_drain) tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
            tx_cnt <= tx_cnt_next;
        end
    end

    // NOTE: FIFO storage has no reset; the counts alone decide which entries are valid, so the array maps onto plain RAM.
    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.writedata;
    end

    assign bus.putFlit_put    = tx_empty ? '0 : tx_mem[tx_rd_ptr];
    assign bus.EN_putFlit_put = tx_drain;

    // ------------------------------------------------------------------
    // RX FIFO: getFlit prefetch in, NIOS reads out
    // ------------------------------------------------------------------
    logic [31:0] rx_mem [DEPTH];
    ptr_t        rx_wr_ptr;
    ptr_t        rx_rd_ptr;
    cnt_t        rx_cnt;
    cnt_t        rx_cnt_next;
    logic        rx_empty;
    logic        rx_fill;
    logic        rx_pop;
    logic        rx_uflow_set;

    assign rx_empty     = (rx_cnt == '0);
    // Fill looks at the count before any same-cycle pop, so a full FIFO never bypasses.
    assign rx_fill      = (rx_cnt != CNT_FULL) && bus.RDY_getFlit_get;
    assign rx_pop       = rd_rx && !rx_empty;
    assign rx_uflow_set = rd_rx && rx_empty;

    always_comb begin
        rx_cnt_next = rx_cnt;
        if (rx_fill && !rx_pop) begin
            rx_cnt_next = rx_cnt + CNT_ONE;
        end else if (rx_pop && !rx_fill) begin
            rx_cnt_next = rx_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else begin
            if (rx_fill) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
            rx_cnt <= rx_cnt_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (rx_fill) rx_mem[rx_wr_ptr] <= bus.getFlit_get;
    end

    assign bus.EN_getFlit_get = rx_fill;

    // ------------------------------------------------------------------
    // Sticky errors, interrupt enable and the registered interrupt
    // ------------------------------------------------------------------
    logic       tx_drop;
    logic       rx_underflow;
    logic [1:0] irq_en;
    logic [1:0] irq_en_next;
    logic       irq_q;

    assign irq_en_next = wr_irq_en ? bus.writedata[1:0] : irq_en;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_drop      <= 1'b0;
            rx_underflow <= 1'b0;
            irq_en       <= 2'b00;
            irq_q        <= 1'b0;
        end else begin
            // A new error event in the same cycle as its write-1-to-clear keeps the bit set.
            tx_drop      <= tx_drop_set  || (tx_drop      && !(wr_status && bus.writedata[2]));
            rx_underflow <= rx_uflow_set || (rx_underflow && !(wr_status && bus.writedata[3]));
            irq_en       <= irq_en_next;
            irq_q        <= (irq_en_next[0] && (rx_cnt_next != '0)) ||
                            (irq_en_next[1] && (tx_cnt_next == '0));
        end
    end

    assign bus.irq = irq_q;

    // ------------------------------------------------------------------
    // Optional flit counters
    // ------------------------------------------------------------------
`ifdef FLIT_MAILBOX_STATS_EN
    logic [31:0] sent_cnt;
    logic [31:0] recv_cnt;
    logic        stats_clr;

    assign stats_clr = bus.write && (bus.address == REG_SENT);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sent_cnt <= '0;
            recv_cnt <= '0;
        end else if (stats_clr) begin
            sent_cnt <= '0;
            recv_cnt <= '0;
        end else begin
            if (tx_drain) sent_cnt <= sent_cnt + 32'd1;
            if (rx_fill)  recv_cnt <= recv_cnt + 32'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read mux: combinational from address, independent of the read strobe
    // ------------------------------------------------------------------
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        case (bus.address)
            REG_STATUS: begin
                rdata = {8'h00, 8'(tx_cnt), 8'(rx_cnt),
                         4'h0, rx_underflow, tx_drop, !tx_full, !rx_empty};
            end
            REG_RX_DATA: begin
                if (!rx_empty) rdata = rx_mem[rx_rd_ptr];
            end
            REG_IRQ_EN: begin
                rdata = {30'h0, irq_en};
            end
`ifdef FLIT_MAILBOX_STATS_EN
            REG_SENT: rdata = sent_cnt;
            REG_RECV: rdata = recv_cnt;
`endif
            default: rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;

    // Data bits with no register behind them.
    logic unused_writedata;
    assign unused_writedata = ^bus.writedata[31:4];

endmodule

// File: tb/tb_fpga1_flit_mailbox.sv
// Self-checking bench for fpga1_flit_mailbox: queue-based reference model, per-cycle compare, directed and random traffic.
// Covers the FLIT_MAILBOX_STATS_EN counters when that macro is defined for the build.
module tb_fpga1_flit_mailbox;
    localparam int DEPTH = 8;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fpga1_flit_mailbox_if mb();

    fpga1_flit_mailbox #(.DEPTH(DEPTH), .AW(3)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (mb)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];
    bit          m_drop   = 0;
    bit          m_uflow  = 0;
    bit [1:0]    m_irq_en = 0;
    bit          m_irq    = 0;
    logic [31:0] m_sent   = 0;
    logic [31:0] m_recv   = 0;

    function automatic logic [31:0] m_rdata(input logic [2:0] a);
        int unsigned v;
        v = 0;
        case (a)
            3'd0: v = (m_rx.size() != 0 ? 1 : 0) + (m_tx.size() != DEPTH ? 2 : 0) +
                      (m_drop ? 4 : 0) + (m_uflow ? 8 : 0) +
                      m_rx.size() * 256 + m_tx.size() * 65536;
            3'd2: v = (m_rx.size() != 0) ? m_rx[0] : 0;
            3'd3: v = m_irq_en;
`ifdef FLIT_MAILBOX_STATS_EN
            3'd4: v = m_sent;
            3'd5: v = m_recv;
`endif
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_tx.delete();
        m_rx.delete();
        m_drop = 0; m_uflow = 0; m_irq_en = 0; m_irq = 0;
        m_sent = 0; m_recv = 0;
    endtask

    task automatic model_step();
        bit drain, fill;
        drain = (m_tx.size() != 0) && (mb.RDY_putFlit_put === 1'b1);
        fill  = (m_rx.size() < DEPTH) && (mb.RDY_getFlit_get === 1'b1);
        if (mb.write && mb.address == 3'd0) begin
            if (mb.writedata[2]) m_drop  = 0;
            if (mb.writedata[3]) m_uflow = 0;
        end
        if (drain) void'(m_tx.pop_front());
        if (mb.write && mb.address == 3'd1) begin
            if (m_tx.size() < DEPTH) m_tx.push_back(mb.writedata);
            else m_drop = 1;
        end
        if (mb.read && mb.address == 3'd2) begin
            if (m_rx.size() != 0) void'(m_rx.pop_front());
            else m_uflow = 1;
        end
        if (fill) m_rx.push_back(mb.getFlit_get);
        if (mb.write && mb.address == 3'd3) m_irq_en = mb.writedata[1:0];
`ifdef FLIT_MAILBOX_STATS_EN
        if (mb.write && mb.address == 3'd4) begin
            m_sent = 0;
            m_recv = 0;
        end else begin
            if (drain) m_sent = m_sent + 1;
            if (fill)  m_recv = m_recv + 1;
        end
`endif
        m_irq = (m_irq_en[0] && m_rx.size() != 0) || (m_irq_en[1] && m_tx.size() == 0);
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) model_reset();
        else model_step();
    end

    // Compare process: inputs change just after posedge, outputs are checked on the falling edge.
    always @(negedge CLK) begin
        bit exp_en_put;
        exp_en_put = (m_tx.size() != 0) && (mb.RDY_putFlit_put === 1'b1);
        check("readdata", mb.readdata, m_rdata(mb.address));
        check("EN_putFlit_put", 32'(mb.EN_putFlit_put), 32'(exp_en_put));
        if (exp_en_put) check("putFlit_put", mb.putFlit_put, m_tx[0]);
        check("EN_getFlit_get", 32'(mb.EN_getFlit_get),
              32'((m_rx.size() < DEPTH) && (mb.RDY_getFlit_get === 1'b1)));
        check("irq", 32'(mb.irq), 32'(m_irq));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        mb.address = a; mb.writedata = d; mb.write = 1'b1;
        step();
        mb.write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        mb.address = a; mb.read = 1'b1;
        #2;
        d = mb.readdata;
        step();
        mb.read = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_seq[$];
        int unsigned op;
        bit          slow_put;

        mb.address = '0; mb.read = 0; mb.write = 0; mb.writedata = '0;
        mb.RDY_putFlit_put = 0; mb.RDY_getFlit_get = 0; mb.getFlit_get = '0;

        // 1. reset state
        step(); step();
        check("rst_irq", 32'(mb.irq), 32'd0);
        check("rst_en_put", 32'(mb.EN_putFlit_put), 32'd0);
        RST_N = 1'b1;
        step();
        bus_read(3'd0, rd);
        check("rst_status", rd, 32'h0000_0002);
        check("rst_en_get", 32'(mb.EN_getFlit_get), 32'd0);

        // 2. single flit out, one-cycle strobe
        mb.RDY_putFlit_put = 1;
        bus_write(3'd1, 32'hDEAD_BEEF);
        check("tx1_en", 32'(mb.EN_putFlit_put), 32'd1);
        check("tx1_data", mb.putFlit_put, 32'hDEAD_BEEF);
        step();
        check("tx1_en_drop", 32'(mb.EN_putFlit_put), 32'd0);

        // 3. overfill TX, then drain in order and clear tx_drop
        mb.RDY_putFlit_put = 0;
        for (int i = 0; i < 9; i++) bus_write(3'd1, 32'h100 + i);
        bus_read(3'd0, rd);
        check("tx_full_status", rd, 32'h0008_0004);
        mb.RDY_putFlit_put = 1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("tx_drain_en", 32'(mb.EN_putFlit_put), 32'd1);
            check("tx_drain_data", mb.putFlit_put, 32'h100 + i);
            step();
        end
        check("tx_drained_en", 32'(mb.EN_putFlit_put), 32'd0);
        bus_write(3'd0, 32'h4);
        bus_read(3'd0, rd);
        check("w1c_drop", rd, 32'h0000_0002);

        // 4. two flits in, irq follows rx occupancy
        mb.getFlit_get = 32'h11; mb.RDY_getFlit_get = 1;
        #1;
        check("rx_en_get", 32'(mb.EN_getFlit_get), 32'd1);
        step();
        mb.getFlit_get = 32'h22;
        step();
        mb.RDY_getFlit_get = 0;
        bus_write(3'd3, 32'h1);
        check("irq_on", 32'(mb.irq), 32'd1);
        bus_read(3'd2, rd);
        check("rx_pop0", rd, 32'h11);
        check("irq_hold", 32'(mb.irq), 32'd1);
        bus_read(3'd2, rd);
        check("rx_pop1", rd, 32'h22);
        check("irq_off", 32'(mb.irq), 32'd0);

        // 5. underflow, then push+drain at full count
        bus_read(3'd2, rd);
        check("rx_empty_read", rd, 32'h0);
        bus_read(3'd0, rd);
        check("uflow_status", rd, 32'h0000_000A);
        bus_write(3'd0, 32'h8);
        mb.RDY_putFlit_put = 0;
        for (int i = 0; i < 8; i++) bus_write(3'd1, 32'h200 + i);
        mb.RDY_putFlit_put = 1;
        bus_write(3'd1, 32'h2FF);
        mb.RDY_putFlit_put = 0;
        bus_read(3'd0, rd);
        check("full_push_drain", rd, 32'h0008_0000);
        for (int i = 1; i < 8; i++) exp_seq.push_back(32'h200 + i);
        exp_seq.push_back(32'h2FF);
        mb.RDY_putFlit_put = 1;
        #1;
        foreach (exp_seq[i]) begin
            check("full_order", mb.putFlit_put, exp_seq[i]);
            step();
        end
        mb.RDY_putFlit_put = 0;

        // 6. flit counters
`ifdef FLIT_MAILBOX_STATS_EN
        bus_write(3'd4, 32'h0);
        bus_read(3'd4, rd);
        check("stats_cleared", rd, 32'h0);
        for (int i = 0; i < 3; i++) bus_write(3'd1, 32'h300 + i);
        mb.RDY_putFlit_put = 1;
        step(); step(); step();
        mb.RDY_putFlit_put = 0;
        mb.RDY_getFlit_get = 1; mb.getFlit_get = 32'h55;
        step(); step();
        mb.RDY_getFlit_get = 0;
        bus_read(3'd4, rd);
        check("stats_sent", rd, 32'd3);
        bus_read(3'd5, rd);
        check("stats_recv", rd, 32'd2);
        bus_write(3'd4, 32'h1234_5678);
        bus_read(3'd4, rd);
        check("stats_sent_clr", rd, 32'd0);
        bus_read(3'd5, rd);
        check("stats_recv_clr", rd, 32'd0);
`else
        bus_write(3'd4, 32'hFFFF_FFFF);
        bus_read(3'd4, rd);
        check("no_stats_4", rd, 32'h0);
        bus_read(3'd5, rd);
        check("no_stats_5", rd, 32'h0);
`endif

        // Random traffic, with one asynchronous reset mid-run.
        for (int i = 0; i < 3000; i++) begin
            op       = $urandom_range(0, 9);
            slow_put = ((i / 300) % 2) == 0;
            mb.read  = 0;
            mb.write = 0;
            if (op < 4) begin
                mb.read    = 1;
                mb.address = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            end else if (op < 8) begin
                mb.write     = 1;
                mb.address   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
                mb.writedata = $urandom;
            end else begin
                mb.address = 3'($urandom_range(0, 7));
            end
            mb.RDY_putFlit_put = slow_put ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            mb.RDY_getFlit_get = slow_put ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            mb.getFlit_get     = $urandom;
            step();
            if (i == 1500) begin
                #2;
                RST_N = 1'b0;
                step();
                step();
                RST_N = 1'b1;
            end
        end

        mb.read = 0; mb.write = 0; mb.RDY_putFlit_put = 0; mb.RDY_getFlit_get = 0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
